// File: rtl/fsm_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : fsm_seq_detector_param
// Purpose  : Parametrised serial sequence detector. Samples one bit of Din on
//            every enabled clock edge and pulses Dout for one cycle each time
//            the last LEN sampled bits equal PATTERN (MSB received first).
//            Matching may overlap (OVERLAP=1) or restart from an empty window
//            after each hit (OVERLAP=0).
// Options  : define FSM_SEQ_DET_COUNT_EN to build the saturating CNT_W-bit
//            match counter; without it Count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_seq_detector_param #(
  parameter int unsigned         LEN     = 3,
  parameter logic [LEN-1:0]      PATTERN = 3'b101,
  parameter int unsigned         OVERLAP = 1,
  parameter int unsigned         CNT_W   = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Din,
  output logic             Dout,
  output logic [CNT_W-1:0] Count
);

  // fill counts 0..LEN, so it needs enough bits to hold LEN itself
  localparam int unsigned        FILL_W   = $clog2(LEN + 1);
  localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(LEN);
  localparam logic [FILL_W-1:0]  FILL_ARM = FILL_W'(LEN - 1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_HUNT = 2'd1,
    S_HIT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LEN-1:0]     hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [FILL_W-1:0]  fill_inc;
  logic [LEN-1:0]     hist_shift;
  logic               match;
  logic               hist_msb_unused;

  // The oldest history bit falls off the end of the shift and is never compared
  assign hist_msb_unused = hist_q[LEN-1];
  assign hist_shift      = {hist_q[LEN-2:0], Din};
  assign fill_inc        = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);

  // Next-state logic: window update, match detection and FSM transitions
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match   = 1'b0;
    if (Enable) begin
      hist_d = hist_shift;
      match  = (hist_shift == PATTERN) && (fill_q >= FILL_ARM);
      if (match) begin
        state_d = S_HIT;
        if (OVERLAP == 0) begin
          // Non-overlapping: the matched bits cannot seed the next match
          hist_d = '0;
          fill_d = '0;
        end else begin
          fill_d = fill_inc;
        end
      end else begin
        fill_d  = fill_inc;
        state_d = (fill_inc == FILL_MAX) ? S_HUNT : S_FILL;
      end
    end else begin
      // A gap always drops out of HIT so the pulse never stretches
      state_d = (fill_q == FILL_MAX) ? S_HUNT : S_FILL;
    end
  end

  // State, history and fill registers with synchronous reset priority
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_FILL;
      hist_q  <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
    end
  end

  // Moore output: high exactly while the FSM sits in HIT
  assign Dout = (state_q == S_HIT);

`ifdef FSM_SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] count_q;

  // Saturating match counter, bumped on every entry into HIT
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= '0;
    end else if (match && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign Count = count_q;
`else
  assign Count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fsm_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_seq_detector_param
// Purpose  : Self-checking bench for fsm_seq_detector_param. Four detector
//            variants share one stimulus stream; a stream-level model predicts
//            Dout/Count for each of them every cycle, and directed scenarios
//            pin the model with literal expectations.
// Options  : Count expectations follow FSM_SEQ_DET_COUNT_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_seq_detector_param;

  localparam int N = 4;

`ifdef FSM_SEQ_DET_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic Clock = 1'b0;
  logic Reset, Enable, Din;
  logic d0, d1, d2, d3;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  logic [3:0] c3;

  always #5 Clock = ~Clock;

  // 0: 101 overlap, 1: 101 non-overlap, 2: 101 overlap 2-bit count, 3: 11011 overlap
  fsm_seq_detector_param #(.LEN(3), .PATTERN(3'b101), .OVERLAP(1), .CNT_W(8)) u_ov (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Din(Din), .Dout(d0), .Count(c0));
  fsm_seq_detector_param #(.LEN(3), .PATTERN(3'b101), .OVERLAP(0), .CNT_W(8)) u_nov (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Din(Din), .Dout(d1), .Count(c1));
  fsm_seq_detector_param #(.LEN(3), .PATTERN(3'b101), .OVERLAP(1), .CNT_W(2)) u_c2 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Din(Din), .Dout(d2), .Count(c2));
  fsm_seq_detector_param #(.LEN(5), .PATTERN(5'b11011), .OVERLAP(1), .CNT_W(4)) u_l5 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Din(Din), .Dout(d3), .Count(c3));

  int len_t [N] = '{3, 3, 3, 5};
  int pat_t [N] = '{5, 5, 5, 27};
  int ovl_t [N] = '{1, 0, 1, 1};
  int cmax_t[N] = '{255, 255, 3, 15};

  // Model: every bit sampled since reset, plus where each variant's window starts
  bit s[$];
  int st[N];
  int mcnt[N];
  bit exp_d[N];

  int total = 0;
  int bad   = 0;

  function automatic bit window_match(int i);
    int base;
    if (s.size() - st[i] < len_t[i]) return 1'b0;
    base = s.size() - len_t[i];
    for (int j = 0; j < len_t[i]; j++) begin
      if (s[base + j] != 1'(pat_t[i] >> (len_t[i] - 1 - j))) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge(input bit r, input bit e, input bit d);
    if (r) begin
      s.delete();
      for (int i = 0; i < N; i++) begin
        st[i] = 0; mcnt[i] = 0; exp_d[i] = 1'b0;
      end
    end else if (e) begin
      s.push_back(d);
      for (int i = 0; i < N; i++) begin
        if (window_match(i)) begin
          exp_d[i] = 1'b1;
          if (mcnt[i] < cmax_t[i]) mcnt[i]++;
          if (ovl_t[i] == 0) st[i] = s.size();
        end else begin
          exp_d[i] = 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) exp_d[i] = 1'b0;
    end
  endtask

  function automatic int act_dout(int i);
    case (i)
      0: return int'(d0);
      1: return int'(d1);
      2: return int'(d2);
      default: return int'(d3);
    endcase
  endfunction

  function automatic int act_cnt(int i);
    case (i)
      0: return int'(c0);
      1: return int'(c1);
      2: return int'(c2);
      default: return int'(c3);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("model_dout[%0d]", i), act_dout(i), int'(exp_d[i]));
      chk($sformatf("model_count[%0d]", i), act_cnt(i), CNT_ON ? mcnt[i] : 0);
    end
  endtask

  // Drive one edge, advance the model, then compare just after the edge
  task automatic step(input bit r, input bit e, input bit d);
    Reset = r; Enable = e; Din = d;
    @(posedge Clock);
    model_edge(r, e, d);
    #1;
    check_all();
  endtask

  function automatic int ec(int n);
    return CNT_ON ? n : 0;
  endfunction

  initial begin
    int seq_ov [5]  = '{0, 0, 1, 0, 1};
    int seq_nov[5]  = '{0, 0, 1, 0, 0};
    int bits5  [5]  = '{1, 0, 1, 0, 1};
    int sat    [5]  = '{1, 2, 3, 3, 3};

    Reset = 1'b1; Enable = 1'b0; Din = 1'b0;
    for (int i = 0; i < N; i++) begin
      st[i] = 0; mcnt[i] = 0; exp_d[i] = 1'b0;
    end

    // Reset state, valid on the first reset edge
    step(1, 1, 1);
    chk("reset_dout", int'(d0), 0);
    chk("reset_count", int'(c0), 0);

    // 1,0,1 -> one pulse, then gone on the next edge
    step(0, 1, 1); step(0, 1, 0); step(0, 1, 1);
    chk("s1_pulse", int'(d0), 1);
    chk("s1_count", int'(c0), ec(1));
    step(0, 0, 0);
    chk("s1_pulse_end", int'(d0), 0);

    // 1,0,1,0,1 overlapping vs non-overlapping
    step(1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 1'(bits5[k]));
      chk($sformatf("s2_ov_edge%0d", k + 1), int'(d0), seq_ov[k]);
      chk($sformatf("s2_nov_edge%0d", k + 1), int'(d1), seq_nov[k]);
    end
    chk("s2_ov_count", int'(c0), ec(2));
    chk("s2_nov_count", int'(c1), ec(1));

    // Enable gap in the middle of a match
    step(1, 0, 0);
    step(0, 1, 1); step(0, 1, 0);
    step(0, 0, 0); chk("s3_gap1", int'(d0), 0);
    step(0, 0, 0); chk("s3_gap2", int'(d0), 0);
    step(0, 1, 1); chk("s3_pulse", int'(d0), 1);

    // Reset on the edge that would complete a match
    step(1, 0, 0);
    step(0, 1, 1); step(0, 1, 0);
    step(1, 1, 1);
    chk("s4_reset_dout", int'(d0), 0);
    chk("s4_reset_count", int'(c0), 0);
    step(0, 1, 1); step(0, 1, 0);
    chk("s4_no_early", int'(d0), 0);
    step(0, 1, 1);
    chk("s4_pulse", int'(d0), 1);
    chk("s4_count", int'(c0), ec(1));

    // 2-bit counter saturation
    step(1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 1); step(0, 1, 0); step(0, 1, 1);
      chk($sformatf("s5_count%0d", k + 1), int'(c2), ec(sat[k]));
      step(0, 1, 0); step(0, 1, 0);
    end
    step(0, 1, 1); step(0, 1, 0);
    step(1, 1, 1);
    chk("s5_reset_dout", int'(d2), 0);
    chk("s5_reset_count", int'(c2), 0);

    // 5-bit overlapping pattern: 11011011 matches twice
    step(1, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 1, 1'((8'b11011011 >> (7 - k))));
    chk("s6_l5_pulse", int'(d3), 1);
    chk("s6_l5_count", int'(c3), ec(2));

    // Randomized traffic checked against the model every cycle
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(99) == 0), ($urandom_range(9) < 8), 1'($urandom_range(1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
